keypad_scanner: RTL and testbench

Scans a 4x4 membrane keypad on the PMOD header: drives the columns, samples the rows and debounces over whole scans. Emits one single-cycle valid pulse carrying a 4-bit hex key code per press. It is the producer side of the calculator's key-entry path. It replaces the per-pin button layer, so the top level receives digit/operator codes instead of one flag per PMOD pin.

---
 rtl/keypad_pkg.sv | 28 ++
 rtl/keypad_col_scan.sv | 64 ++++++
 rtl/keypad_scanner.sv | 121 ++++++++++++
 tb/tb_keypad_scanner.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/keypad_pkg.sv
// Shared types and constants for the 4x4 keypad scanner.
package keypad_pkg;

    localparam int unsigned ROWS   = 4;
    localparam int unsigned COLS   = 4;
    localparam int unsigned KEYS   = ROWS * COLS;
    localparam int unsigned CODE_W = 4;

    typedef enum logic [1:0] {
        ARMED,
        PRESS_DEB,
        HELD,
        RELEASE_DEB
    } key_state_t;

    // Indexed by row*4 + col: 1 2 3 A / 4 5 6 B / 7 8 9 C / 0 F E D
    localparam logic [CODE_W-1:0] KEY_MAP [KEYS] = '{
        4'h1, 4'h2, 4'h3, 4'hA,
        4'h4, 4'h5, 4'h6, 4'hB,
        4'h7, 4'h8, 4'h9, 4'hC,
        4'h0, 4'hF, 4'hE, 4'hD
    };

    function automatic logic [CODE_W-1:0] key_code(input logic [3:0] idx);
        return KEY_MAP[idx];
    endfunction

endpackage

// File: rtl/keypad_col_scan.sv
// Column driver, row synchronizer and per-scan snapshot assembly.
module keypad_col_scan
    import keypad_pkg::*;
#(
    parameter int unsigned CLKS_PER_COL = 25000
) (
    input  logic                i_Clk,
    input  logic                i_Rst,
    input  logic [ROWS-1:0]     row,
    output logic [COLS-1:0]     col,
    output logic [KEYS-1:0]     snapshot,
    output logic                scan_done
);

    localparam int unsigned DWELL_W = $clog2(CLKS_PER_COL);

    logic [DWELL_W-1:0] dwell;
    logic [1:0]         col_idx;
    logic [ROWS-1:0]    row_meta;
    logic [ROWS-1:0]    row_sync;
    logic [KEYS-1:0]    acc;
    logic [KEYS-1:0]    acc_next_c;
    logic               last_dwell_c;

    assign last_dwell_c = (dwell == DWELL_W'(CLKS_PER_COL - 1));

    // Merge the current column's (inverted) rows into the snapshot
    always_comb begin
        acc_next_c = acc;
        for (int r = 0; r < int'(ROWS); r++) begin
            acc_next_c[{2'(r), col_idx}] = ~row_sync[r];
        end
    end

    always_ff @(posedge i_Clk or posedge i_Rst) begin
        if (i_Rst) begin
            dwell     <= '0;
            col_idx   <= 2'd0;
            col       <= 4'b1110;
            row_meta  <= '1;
            row_sync  <= '1;
            acc       <= '0;
            snapshot  <= '0;
            scan_done <= 1'b0;
        end else begin
            row_meta  <= row;
            row_sync  <= row_meta;
            scan_done <= 1'b0;
            if (last_dwell_c) begin
                dwell   <= '0;
                col_idx <= col_idx + 2'd1;
                col     <= {col[COLS-2:0], col[COLS-1]};
                acc     <= acc_next_c;
                if (col_idx == 2'd3) begin
                    snapshot  <= acc_next_c;
                    scan_done <= 1'b1;
                end
            end else begin
                dwell <= dwell + DWELL_W'(1);
            end
        end
    end

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 keypad scanner: classifies each full scan and debounces press/release.
module keypad_scanner
    import keypad_pkg::*;
#(
    parameter int unsigned CLKS_PER_COL   = 25000,
    parameter int unsigned DEBOUNCE_SCANS = 4
) (
    input  logic              i_Clk,
    input  logic              i_Rst,
    output logic [COLS-1:0]   o_Col,
    input  logic [ROWS-1:0]   i_Row,
    output logic              o_Key_Valid,
    output logic [CODE_W-1:0] o_Key_Code,
    output logic              o_Key_Held
);

    localparam int unsigned CNT_W = $clog2(DEBOUNCE_SCANS + 1);

    logic [KEYS-1:0] snapshot;
    logic            scan_done;
    logic [4:0]      ones_c;
    logic [3:0]      key_idx_c;
    logic            single_c;

    key_state_t      state;
    logic [3:0]      cand;
    logic [CNT_W-1:0] cnt;

    keypad_col_scan #(
        .CLKS_PER_COL (CLKS_PER_COL)
    ) u_col_scan (
        .i_Clk     (i_Clk),
        .i_Rst     (i_Rst),
        .row       (i_Row),
        .col       (o_Col),
        .snapshot  (snapshot),
        .scan_done (scan_done)
    );

    // Multi-key snapshots count as "none" to reject ghosting
    always_comb begin
        ones_c    = '0;
        key_idx_c = '0;
        for (int i = 0; i < int'(KEYS); i++) begin
            if (snapshot[i]) begin
                ones_c    = ones_c + 5'd1;
                key_idx_c = 4'(i);
            end
        end
        single_c = (ones_c == 5'd1);
    end

    always_ff @(posedge i_Clk or posedge i_Rst) begin
        if (i_Rst) begin
            state       <= ARMED;
            cand        <= '0;
            cnt         <= '0;
            o_Key_Valid <= 1'b0;
            o_Key_Code  <= '0;
            o_Key_Held  <= 1'b0;
        end else begin
            o_Key_Valid <= 1'b0;
            if (scan_done) begin
                case (state)
                    ARMED: begin
                        if (single_c) begin
                            cand <= key_idx_c;
                            if (DEBOUNCE_SCANS == 1) begin
                                o_Key_Code  <= key_code(key_idx_c);
                                o_Key_Valid <= 1'b1;
                                o_Key_Held  <= 1'b1;
                                state       <= HELD;
                            end else begin
                                cnt   <= CNT_W'(1);
                                state <= PRESS_DEB;
                            end
                        end
                    end
                    PRESS_DEB: begin
                        if (!single_c) begin
                            state <= ARMED;
                        end else if (key_idx_c != cand) begin
                            cand <= key_idx_c;
                            cnt  <= CNT_W'(1);
                        end else if (cnt == CNT_W'(DEBOUNCE_SCANS - 1)) begin
                            o_Key_Code  <= key_code(cand);
                            o_Key_Valid <= 1'b1;
                            o_Key_Held  <= 1'b1;
                            state       <= HELD;
                        end else begin
                            cnt <= cnt + CNT_W'(1);
                        end
                    end
                    HELD: begin
                        if (!single_c) begin
                            if (DEBOUNCE_SCANS == 1) begin
                                o_Key_Held <= 1'b0;
                                state      <= ARMED;
                            end else begin
                                cnt   <= CNT_W'(1);
                                state <= RELEASE_DEB;
                            end
                        end
                    end
                    RELEASE_DEB: begin
                        if (single_c) begin
                            state <= HELD;
                        end else if (cnt == CNT_W'(DEBOUNCE_SCANS - 1)) begin
                            o_Key_Held <= 1'b0;
                            state      <= ARMED;
                        end else begin
                            cnt <= cnt + CNT_W'(1);
                        end
                    end
                    default: state <= ARMED;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_keypad_scanner.sv
// Scoreboard bench: per-scan key patterns, behavioural debounce model, pulse monitor.
module tb_keypad_scanner;

    localparam int CPC  = 4;
    localparam int DEB  = 2;
    localparam int SCAN = 4 * CPC;

    typedef struct {
        int code;
        int cyc;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] o_Col;
    logic [3:0] i_Row;
    logic       o_Key_Valid;
    logic [3:0] o_Key_Code;
    logic       o_Key_Held;

    logic [15:0] keys = '0;
    int          cyc;
    int          n_vec = 0;
    int          n_err = 0;
    exp_t        exp_q[$];

    int KEY_CODE [16] = '{1, 2, 3, 10, 4, 5, 6, 11, 7, 8, 9, 12, 0, 15, 14, 13};

    // Reference model state
    int m_held = 0;
    int m_cand = -1;
    int m_cnt  = 0;
    int m_rel  = 0;
    int m_code = 0;

    keypad_scanner #(
        .CLKS_PER_COL   (CPC),
        .DEBOUNCE_SCANS (DEB)
    ) dut (
        .i_Clk       (clk),
        .i_Rst       (rst),
        .o_Col       (o_Col),
        .i_Row       (i_Row),
        .o_Key_Valid (o_Key_Valid),
        .o_Key_Code  (o_Key_Code),
        .o_Key_Held  (o_Key_Held)
    );

    always #5 clk = ~clk;

    // Membrane keypad: a pressed key pulls its row low while its column is driven low
    always_comb begin
        for (int r = 0; r < 4; r++) begin
            i_Row[r] = ~|(keys[r*4 +: 4] & ~o_Col);
        end
    end

    always @(posedge clk or posedge rst) begin
        if (rst) cyc <= 0;
        else     cyc <= cyc + 1;
    end

    function automatic logic [15:0] key(input int r, input int c);
        logic [15:0] one;
        one = 16'd1;
        return one << (r * 4 + c);
    endfunction

    function automatic int classify(input logic [15:0] k);
        int n;
        int idx;
        n = 0;
        idx = -1;
        for (int i = 0; i < 16; i++) begin
            if (k[i]) begin
                n++;
                idx = i;
            end
        end
        return (n == 1) ? idx : -1;
    endfunction

    // One completed scan of the reference debouncer; a press is accepted after DEB identical single scans
    task automatic model_scan(input logic [15:0] k_mask);
        int k;
        exp_t e;
        k = classify(k_mask);
        if (m_held == 0) begin
            if (k < 0) begin
                m_cand = -1;
                m_cnt  = 0;
            end else if (k == m_cand) begin
                m_cnt++;
            end else begin
                m_cand = k;
                m_cnt  = 1;
            end
            if (m_cand >= 0 && m_cnt >= DEB) begin
                e.code = KEY_CODE[m_cand];
                e.cyc  = cyc + 1;
                exp_q.push_back(e);
                m_code = KEY_CODE[m_cand];
                m_held = 1;
                m_cnt  = 0;
                m_rel  = 0;
            end
        end else begin
            if (k < 0) begin
                m_rel++;
                if (m_rel >= DEB) begin
                    m_held = 0;
                    m_rel  = 0;
                    m_cand = -1;
                    m_cnt  = 0;
                end
            end else begin
                m_rel = 0;
            end
        end
    endtask

    task automatic model_reset();
        m_held = 0;
        m_cand = -1;
        m_cnt  = 0;
        m_rel  = 0;
        m_code = 0;
    endtask

    // Called at a scan boundary (negedge, cyc multiple of SCAN)
    task automatic run_scan(input logic [15:0] k_mask);
        keys = k_mask;
        @(negedge clk);
        n_vec++;
        if (o_Key_Held !== m_held[0] || o_Key_Code !== 4'(m_code)) begin
            n_err++;
            $display("FAIL held/code at cyc %0d: got held=%0b code=%h, want held=%0b code=%h",
                     cyc, o_Key_Held, o_Key_Code, m_held[0], 4'(m_code));
        end
        repeat (SCAN - 1) @(negedge clk);
        model_scan(k_mask);
    endtask

    task automatic run_scans(input logic [15:0] k_mask, input int n);
        for (int i = 0; i < n; i++) run_scan(k_mask);
    endtask

    // Monitor: column walk every cycle, pulses popped from the scoreboard
    always @(negedge clk) begin
        if (!rst) begin
            logic [3:0] want_col;
            want_col = ~(4'b0001 << cyc[3:2]);
            n_vec++;
            if (o_Col !== want_col) begin
                n_err++;
                $display("FAIL col at cyc %0d: got %b, want %b", cyc, o_Col, want_col);
            end
            if (o_Key_Valid) begin
                n_vec++;
                if (exp_q.size() == 0) begin
                    n_err++;
                    $display("FAIL pulse at cyc %0d: got code %h, want no pulse", cyc, o_Key_Code);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    if (o_Key_Code !== 4'(e.code) || cyc != e.cyc) begin
                        n_err++;
                        $display("FAIL pulse: got code %h at cyc %0d, want code %h at cyc %0d",
                                 o_Key_Code, cyc, 4'(e.code), e.cyc);
                    end
                end
            end
        end
    end

    initial begin
        #2ms;
        $display("FAIL timeout: bench did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic [15:0] pat;
        int len;
        int sel;

        rst = 1'b1;
        repeat (3) @(negedge clk);
        n_vec++;
        if (o_Col !== 4'b1110 || o_Key_Valid !== 1'b0 || o_Key_Code !== 4'h0 || o_Key_Held !== 1'b0) begin
            n_err++;
            $display("FAIL reset state: got col=%b v=%b code=%h held=%b, want 1110 0 0 0",
                     o_Col, o_Key_Valid, o_Key_Code, o_Key_Held);
        end
        rst = 1'b0;

        // Idle scans
        run_scans('0, 10);
        // Key 5 held, then released
        run_scans(key(1, 1), 6);
        run_scans('0, 4);
        // Key D bounces on/off/on/on
        run_scan(key(3, 3));
        run_scan('0);
        run_scans(key(3, 3), 2);
        run_scans('0, 3);
        // 1+A ghost rejected, then 1 alone
        run_scans(key(0, 0) | key(0, 3), 3);
        run_scans(key(0, 0), 3);
        run_scans('0, 3);
        // Rollover 7 -> 0, then a fresh 0 press
        run_scans(key(2, 0), 3);
        run_scan(key(2, 0) | key(3, 0));
        run_scans(key(3, 0), 3);
        run_scans('0, 2);
        run_scans(key(3, 0), 3);
        run_scans('0, 3);

        // Random key patterns with random run lengths
        for (int s = 0; s < 40; s++) begin
            sel = int'($urandom_range(0, 9));
            if (sel < 3) pat = '0;
            else if (sel < 9) pat = key(int'($urandom_range(0, 3)), int'($urandom_range(0, 3)));
            else pat = key(int'($urandom_range(0, 3)), int'($urandom_range(0, 3)))
                     | key(int'($urandom_range(0, 3)), int'($urandom_range(0, 3)));
            len = int'($urandom_range(1, 4));
            run_scans(pat, len);
        end
        run_scans('0, 3);

        // Reset during press debounce of 9
        run_scan(key(2, 2));
        keys = key(2, 2);
        repeat (SCAN / 2) @(negedge clk);
        rst = 1'b1;
        #1;
        n_vec++;
        if (o_Col !== 4'b1110 || o_Key_Valid !== 1'b0 || o_Key_Code !== 4'h0 || o_Key_Held !== 1'b0) begin
            n_err++;
            $display("FAIL mid-debounce reset: got col=%b v=%b code=%h held=%b, want 1110 0 0 0",
                     o_Col, o_Key_Valid, o_Key_Code, o_Key_Held);
        end
        model_reset();
        repeat (2) @(negedge clk);
        rst = 1'b0;
        run_scans(key(2, 2), 3);
        run_scans('0, 3);

        repeat (20) @(negedge clk);
        n_vec++;
        if (exp_q.size() != 0) begin
            n_err++;
            $display("FAIL missing pulses: got %0d still pending, want 0", exp_q.size());
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
